// File: rtl/clk_period_meter.sv
// Measures period and high time of a divided clock (already in the in_clk domain)
// and hands each measurement to a consumer over a valid/ready interface.
module clk_period_meter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 in_clk,
  input  logic                 reset_l,
  input  logic                 sig_in,
  input  logic                 enable,
  input  logic                 clr,
  output logic                 meas_valid,
  input  logic                 meas_ready,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 overrun,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    MEASURE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 sig_d_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] high_cap_q, high_cap_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_time_q, high_time_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;

  logic rise_c, fall_c, result_c, timeout_set_c, overrun_set_c;

  assign rise_c = sig_in & ~sig_d_q;
  assign fall_c = ~sig_in & sig_d_q;

  // Measurement FSM: a result is produced on every rise after the first one.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    high_cap_d    = high_cap_q;
    result_c      = 1'b0;
    timeout_set_c = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = SYNC;
        end
        SYNC: begin
          if (rise_c) begin
            cnt_d   = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          cnt_d = cnt_q + CNT_ONE;
          if (fall_c) high_cap_d = cnt_q;
          if (rise_c) begin
            result_c = 1'b1;
            cnt_d    = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            timeout_set_c = 1'b1;
            cnt_d         = '0;
            state_d       = SYNC;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output slot: a new result is dropped (and flagged) only if the held one is not being taken.
  always_comb begin
    period_d      = period_q;
    high_time_d   = high_time_q;
    valid_d       = valid_q;
    overrun_set_c = 1'b0;
    if (result_c) begin
      if (!valid_q || meas_ready) begin
        period_d    = cnt_q;
        high_time_d = high_cap_q;
        valid_d     = 1'b1;
      end else begin
        overrun_set_c = 1'b1;
      end
    end else if (valid_q && meas_ready) begin
      valid_d = 1'b0;
    end
    overrun_d = overrun_set_c | (overrun_q & ~clr);
    timeout_d = timeout_set_c | (timeout_q & ~clr);
  end

  always_ff @(posedge in_clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= IDLE;
      sig_d_q     <= 1'b0;
      cnt_q       <= '0;
      high_cap_q  <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_d_q     <= sig_in;
      cnt_q       <= cnt_d;
      high_cap_q  <= high_cap_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign meas_valid = valid_q;
  assign period     = period_q;
  assign high_time  = high_time_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule
